// File: rtl/robot_nav_ctrl.sv
// rtl/robot_nav_ctrl.sv - colour-debounced navigation FSM driving five motor command lines
// Optional feature macro: NAV_TURN_ABORT_EN (cd low during TURN aborts the turn)
module robot_nav_ctrl #(
   parameter int NUM_COLORS  = 5,
   parameter int IDX_W       = 3,
   parameter int DEB_CYCLES  = 4,
   parameter int CNT_W       = 8,
   parameter int TURN_CYCLES = 16,
   parameter logic [2*NUM_COLORS-1:0] ACTION_MAP = 10'h1E4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cd,
   input  logic [NUM_COLORS-1:0] color,
   output logic                  stop_motor,
   output logic                  front_motor,
   output logic                  turn_left,
   output logic                  turn_right,
   output logic                  rotate,
   output logic                  act_valid,
   output logic [IDX_W-1:0]      act_color,
   output logic [2:0]            state
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_DRIVE    = 3'd1,
      S_DEBOUNCE = 3'd2,
      S_TURN     = 3'd3,
      S_STOP     = 3'd4
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_timer;
   logic [IDX_W-1:0] r_cand;
   logic [1:0]       r_action;
   logic             r_act_valid;
   logic [IDX_W-1:0] r_act_color;

   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_timer_nxt;
   logic [IDX_W-1:0] w_cand_nxt;
   logic [1:0]       w_action_nxt;
   logic             w_act_valid_nxt;
   logic [IDX_W-1:0] w_act_color_nxt;
   logic [IDX_W-1:0] w_low;
   logic [IDX_W-1:0] w_acc_idx;
   logic             w_accept;
   logic [1:0]       w_acc_action;

   // Lowest set colour index wins when several detections are high
   always_comb begin
      w_low = '0;
      for (int i = NUM_COLORS - 1; i >= 0; i--) begin
         if (color[i]) w_low = IDX_W'(i);
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_timer_nxt     = r_timer;
      w_cand_nxt      = r_cand;
      w_action_nxt    = r_action;
      w_act_valid_nxt = 1'b0;
      w_act_color_nxt = r_act_color;
      w_accept        = 1'b0;
      w_acc_idx       = r_cand;
      w_acc_action    = 2'b00;
      case (r_state)
         S_IDLE: begin
            if (cd) w_state_nxt = S_DRIVE;
         end
         S_DRIVE: begin
            if (!cd) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else if (|color) begin
               w_cand_nxt = w_low;
               if (DEB_CYCLES == 1) begin
                  w_accept  = 1'b1;
                  w_acc_idx = w_low;
               end else begin
                  w_cnt_nxt   = CNT_W'(1);
                  w_state_nxt = S_DEBOUNCE;
               end
            end
         end
         S_DEBOUNCE: begin
            if (!cd) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else if (!color[r_cand]) begin
               w_state_nxt = S_DRIVE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
               w_accept = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_TURN: begin
`ifdef NAV_TURN_ABORT_EN
            if (!cd) begin
               w_state_nxt = S_IDLE;
               w_timer_nxt = '0;
            end else if (r_timer == '0) begin
               w_state_nxt = S_DRIVE;
            end else begin
               w_timer_nxt = r_timer - CNT_W'(1);
            end
`else
            if (r_timer == '0) begin
               w_state_nxt = cd ? S_DRIVE : S_IDLE;
            end else begin
               w_timer_nxt = r_timer - CNT_W'(1);
            end
`endif
         end
         S_STOP: begin
            if (!cd) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase

      if (w_accept) begin
         w_acc_action    = ACTION_MAP[{w_acc_idx, 1'b0} +: 2];
         w_act_valid_nxt = 1'b1;
         w_act_color_nxt = w_acc_idx;
         w_action_nxt    = w_acc_action;
         w_cnt_nxt       = '0;
         if (w_acc_action == 2'b00) begin
            w_state_nxt = S_STOP;
         end else begin
            w_state_nxt = S_TURN;
            w_timer_nxt = CNT_W'(TURN_CYCLES - 1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_timer     <= '0;
         r_cand      <= '0;
         r_action    <= 2'b00;
         r_act_valid <= 1'b0;
         r_act_color <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_timer     <= w_timer_nxt;
         r_cand      <= w_cand_nxt;
         r_action    <= w_action_nxt;
         r_act_valid <= w_act_valid_nxt;
         r_act_color <= w_act_color_nxt;
      end
   end

   // Moore decode; unreachable codes show as stopped until they fall back to IDLE
   always_comb begin
      stop_motor  = 1'b0;
      front_motor = 1'b0;
      turn_left   = 1'b0;
      turn_right  = 1'b0;
      rotate      = 1'b0;
      case (r_state)
         S_DRIVE, S_DEBOUNCE: front_motor = 1'b1;
         S_TURN: begin
            turn_left  = (r_action == 2'b01);
            turn_right = (r_action == 2'b10);
            rotate     = (r_action == 2'b11);
         end
         default: stop_motor = 1'b1;
      endcase
   end

   assign act_valid = r_act_valid;
   assign act_color = r_act_color;
   assign state     = r_state;

endmodule
